// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin, burst-bounded sharing of one
// single read/write-port word memory between two requesters.
module mem_port_arbiter #(
   parameter int DEPTH     = 1024,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             we0,
   input  logic [31:0]      addr0,
   input  logic [31:0]      wdata0,
   output logic             gnt0,
   output logic             rvalid0,
   output logic [31:0]      rdata0,
   output logic             err0,
   input  logic             req1,
   input  logic             we1,
   input  logic [31:0]      addr1,
   input  logic [31:0]      wdata1,
   output logic             gnt1,
   output logic             rvalid1,
   output logic [31:0]      rdata1,
   output logic             err1,
   output logic             mem_we,
   output logic [31:0]      mem_raddr,
   output logic [31:0]      mem_waddr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [CNT_W-1:0] gcnt0,
   output logic [CNT_W-1:0] gcnt1
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

   logic             last_q, last_d;
   logic [BW-1:0]    burst_q, burst_d;
   logic             rvalid0_q, rvalid0_d;
   logic             rvalid1_q, rvalid1_d;
   logic [31:0]      rdata0_q, rdata0_d;
   logic [31:0]      rdata1_q, rdata1_d;
   logic             err0_q, err0_d;
   logic             err1_q, err1_d;
   logic [CNT_W-1:0] gcnt0_q, gcnt0_d;
   logic [CNT_W-1:0] gcnt1_q, gcnt1_d;

   logic sel1;
   logic any_req;
   logic oor0;
   logic oor1;

   assign oor0 = (addr0 >= 32'(DEPTH));
   assign oor1 = (addr1 >= 32'(DEPTH));

   // burst_q == 0 only after reset: no burst to hold, so rotate
   always_comb begin
      sel1 = req1;
      if (req0 && req1) begin
         if (burst_q != '0 && burst_q < BMAX) sel1 = last_q;
         else sel1 = ~last_q;
      end
   end

   assign any_req = (req0 | req1) & ~rst;
   assign gnt0    = any_req & ~sel1;
   assign gnt1    = any_req & sel1;

   assign mem_raddr = gnt1 ? addr1 : addr0;
   assign mem_waddr = gnt1 ? addr1 : addr0;
   assign mem_wdata = gnt1 ? wdata1 : wdata0;
   assign mem_we    = (gnt0 & we0 & ~oor0) | (gnt1 & we1 & ~oor1);

   always_comb begin
      last_d  = last_q;
      burst_d = burst_q;
      if (gnt0 || gnt1) begin
         if (gnt1 == last_q) begin
            burst_d = (burst_q == BMAX) ? BMAX : burst_q + BW'(1);
         end else begin
            last_d  = gnt1;
            burst_d = BW'(1);
         end
      end
   end

   always_comb begin
      rvalid0_d = 1'b0;
      err0_d    = 1'b0;
      rdata0_d  = rdata0_q;
      if (gnt0) begin
         err0_d = oor0;
         if (!we0) begin
            rvalid0_d = 1'b1;
            rdata0_d  = oor0 ? '0 : mem_rdata;
         end
      end
   end

   always_comb begin
      rvalid1_d = 1'b0;
      err1_d    = 1'b0;
      rdata1_d  = rdata1_q;
      if (gnt1) begin
         err1_d = oor1;
         if (!we1) begin
            rvalid1_d = 1'b1;
            rdata1_d  = oor1 ? '0 : mem_rdata;
         end
      end
   end

   always_comb begin
      gcnt0_d = gcnt0_q;
      gcnt1_d = gcnt1_q;
      if (gnt0 && !(&gcnt0_q)) gcnt0_d = gcnt0_q + CNT_W'(1);
      if (gnt1 && !(&gcnt1_q)) gcnt1_d = gcnt1_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q    <= 1'b1;
         burst_q   <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         err0_q    <= 1'b0;
         err1_q    <= 1'b0;
         gcnt0_q   <= '0;
         gcnt1_q   <= '0;
      end else begin
         last_q    <= last_d;
         burst_q   <= burst_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         err0_q    <= err0_d;
         err1_q    <= err1_d;
         gcnt0_q   <= gcnt0_d;
         gcnt1_q   <= gcnt1_d;
      end
   end

   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;
   assign err0    = err0_q;
   assign err1    = err1_q;
   assign gcnt0   = gcnt0_q;
   assign gcnt1   = gcnt1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with queued expectations
// checked by an independent negedge monitor.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        v;
      logic        e;
      logic [31:0] d;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, we0 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0;
   logic        req1 = 1'b0, we1 = 1'b0;
   logic [31:0] addr1 = '0, wdata1 = '0;
   logic        gnt0, rvalid0, err0;
   logic [31:0] rdata0;
   logic        gnt1, rvalid1, err1;
   logic [31:0] rdata1;
   logic        mem_we;
   logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
   logic [15:0] gcnt0, gcnt1;

   logic [31:0] mem [0:1023];

   int   n_cmp = 0;
   int   n_err = 0;
   int   gq[$];
   rsp_t q0[$];
   rsp_t q1[$];

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
      .mem_we(mem_we), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .gcnt0(gcnt0), .gcnt1(gcnt1)
   );

   assign mem_rdata = mem[mem_raddr[9:0]];

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[0]    = 32'h1111_0000;
      mem[1]    = 32'h2222_0001;
      mem[7]    = 32'h0000_0077;
      mem[13]   = 32'd9;
      mem[1023] = 32'h0000_ABCD;
      forever begin
         @(posedge clk);
         if (mem_we) mem[mem_waddr[9:0]] <= mem_wdata;
      end
   end

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cycle();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      int   e;
      rsp_t r;
      if (!rst) begin
         if (gnt0 || gnt1) begin
            if (gq.size() == 0) check("gnt_unexpected", {gnt1, gnt0}, 0);
            else begin
               e = gq.pop_front();
               check("gnt", {gnt1, gnt0}, (e == 1) ? 2'b10 : 2'b01);
            end
         end
         if (rvalid0 || err0) begin
            if (q0.size() == 0) check("rsp0_unexpected", {rvalid0, err0}, 0);
            else begin
               r = q0.pop_front();
               check("rsp0", {rvalid0, err0, rdata0}, r);
            end
         end
         if (rvalid1 || err1) begin
            if (q1.size() == 0) check("rsp1_unexpected", {rvalid1, err1}, 0);
            else begin
               r = q1.pop_front();
               check("rsp1", {rvalid1, err1, rdata1}, r);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // reset holds grants and writes off even with a request present
      drive(1, 1, 3, 32'h33, 1, 0, 1, 0);
      @(negedge clk);
      check("rst_gnt", {gnt1, gnt0}, 0);
      check("rst_we", mem_we, 0);
      check("rst_out", {rvalid0, err0, rvalid1, err1}, 0);
      check("rst_gcnt", {gcnt1, gcnt0}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      drive(1, 0, 13, 0, 0, 0, 0, 0);
      gq.push_back(0);
      q0.push_back({1'b1, 1'b0, 32'd9});
      cycle();
      idle();
      @(negedge clk);
      check("gcnt0_first", gcnt0, 1);
      @(posedge clk);
      #1;

      rst = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive(1, 0, 0, 0, 1, 0, 1, 0);
         if (i < 4 || i >= 8) begin
            gq.push_back(0);
            q0.push_back({1'b1, 1'b0, 32'h1111_0000});
         end else begin
            gq.push_back(1);
            q1.push_back({1'b1, 1'b0, 32'h2222_0001});
         end
         cycle();
      end
      idle();
      @(negedge clk);
      check("gcnt0_tie", gcnt0, 8);
      check("gcnt1_tie", gcnt1, 4);
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 1, 0, 1, 0);
         gq.push_back(1);
         q1.push_back({1'b1, 1'b0, 32'h2222_0001});
         cycle();
      end
      drive(1, 0, 13, 0, 1, 0, 1, 0);
      gq.push_back(0);
      q0.push_back({1'b1, 1'b0, 32'd9});
      cycle();
      idle();
      cycle();

      drive(0, 0, 0, 0, 1, 1, 5, 32'hDEAD_BEEF);
      gq.push_back(1);
      @(negedge clk);
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_waddr, 5);
      check("wr_data", mem_wdata, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      drive(1, 0, 5, 0, 0, 0, 0, 0);
      gq.push_back(0);
      q0.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
      cycle();
      idle();
      cycle();

      drive(1, 1, 1024, 7, 0, 0, 0, 0);
      gq.push_back(0);
      q0.push_back({1'b0, 1'b1, 32'hDEAD_BEEF});
      @(negedge clk);
      check("oor_we", mem_we, 0);
      @(posedge clk);
      #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      gq.push_back(0);
      q0.push_back({1'b1, 1'b0, 32'h1111_0000});
      cycle();
      drive(1, 0, 32'h8000_0005, 0, 0, 0, 0, 0);
      gq.push_back(0);
      q0.push_back({1'b1, 1'b1, 32'h0});
      cycle();
      drive(1, 0, 1023, 0, 0, 0, 0, 0);
      gq.push_back(0);
      q0.push_back({1'b1, 1'b0, 32'h0000_ABCD});
      cycle();
      idle();
      cycle();

      drive(0, 0, 0, 0, 1, 1, 7, 32'h55);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_gnt", {gnt1, gnt0}, 0);
      check("mid_rst_we", mem_we, 0);
      check("mid_rst_out", {rvalid0, err0, rvalid1, err1}, 0);
      check("mid_rst_gcnt", {gcnt1, gcnt0}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1, 0, 13, 0, 1, 0, 7, 0);
      gq.push_back(0);
      q0.push_back({1'b1, 1'b0, 32'd9});
      cycle();
      drive(0, 0, 0, 0, 1, 0, 7, 0);
      gq.push_back(1);
      q1.push_back({1'b1, 1'b0, 32'h0000_0077});
      cycle();
      idle();
      cycle();
      cycle();

      check("gq_drained", gq.size(), 0);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
